// File: rtl/secure_sram_rekey.sv
// Secure SRAM with on-chip key pair and crypto-erase scrub on dcr.
// Host reads have a fixed two-edge latency; rekey count saturates.
module secure_sram_rekey #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 52,
    parameter int TRNG_A_WIDTH = 64,
    parameter int TRNG_D_WIDTH = 32,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dcr,
    input  logic [TRNG_A_WIDTH-1:0] trng_a_in,
    input  logic [TRNG_D_WIDTH-1:0] trng_d_in,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    rekey_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SCRUB  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [TRNG_A_WIDTH-1:0] key_a_q, key_a_d;
    logic [TRNG_D_WIDTH-1:0] key_d_q, key_d_d;
    logic [ADDR_WIDTH-1:0]   scrub_ptr_q, scrub_ptr_d;
    logic [CNT_WIDTH-1:0]    rekey_cnt_q, rekey_cnt_d;
    logic                    rd_v_q, rd_v_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0]   rd_kd_q, rd_kd_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [DATA_WIDTH-1:0]   kd;
    logic [ADDR_WIDTH-1:0]   phys;
    logic                    accept;
    logic [TRNG_A_WIDTH-1:0] unused_key_a;

    // Only the low address bits of key_a steer the map.
    assign unused_key_a = key_a_q;

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_kd
        assign kd[g] = key_d_q[g % TRNG_D_WIDTH];
    end

    assign req_ready = (state_q == ST_ACTIVE);
    assign busy      = ~req_ready;
    assign accept    = req_valid && req_ready;
    assign phys      = req_addr ^ key_a_q[ADDR_WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        key_a_d     = key_a_q;
        key_d_d     = key_d_q;
        scrub_ptr_d = scrub_ptr_q;
        mem_we      = 1'b0;
        mem_waddr   = phys;
        mem_wdata   = req_wdata ^ kd;
        rd_v_d      = accept && !req_we;
        rd_data_d   = rd_data_q;
        rd_kd_d     = rd_kd_q;
        rsp_valid_d = rd_v_q;
        rsp_rdata_d = rsp_rdata_q;
        rekey_cnt_d = rekey_cnt_q;

        // Reads carry their own kd so a later rekey cannot corrupt them.
        if (accept && !req_we) begin
            rd_data_d = mem_q[phys];
            rd_kd_d   = kd;
        end
        if (rd_v_q) begin
            rsp_rdata_d = rd_data_q ^ rd_kd_q;
        end

        case (state_q)
            ST_LOAD: begin
                key_a_d     = trng_a_in;
                key_d_d     = trng_d_in;
                scrub_ptr_d = '0;
                state_d     = ST_SCRUB;
            end
            ST_SCRUB: begin
                mem_we      = 1'b1;
                mem_waddr   = scrub_ptr_q;
                mem_wdata   = kd;
                scrub_ptr_d = scrub_ptr_q + 1'b1;
                if (&scrub_ptr_q) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                mem_we = accept && req_we;
            end
            default: state_d = ST_LOAD;
        endcase

        if (dcr) begin
            state_d = ST_LOAD;
            if (!(&rekey_cnt_q)) begin
                rekey_cnt_d = rekey_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            key_a_q     <= '0;
            key_d_q     <= '0;
            scrub_ptr_q <= '0;
            rekey_cnt_q <= '0;
            rd_v_q      <= 1'b0;
            rd_data_q   <= '0;
            rd_kd_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            key_a_q     <= key_a_d;
            key_d_q     <= key_d_d;
            scrub_ptr_q <= scrub_ptr_d;
            rekey_cnt_q <= rekey_cnt_d;
            rd_v_q      <= rd_v_d;
            rd_data_q   <= rd_data_d;
            rd_kd_q     <= rd_kd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Storage is deliberately unreset; the post-reset scrub clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rekey_cnt = rekey_cnt_q;

endmodule

// File: tb/tb_secure_sram_rekey.sv
// Bench for secure_sram_rekey: vector table plus rekey corner sequences.
// Read expectations go through a scoreboard queue popped on rsp_valid.
module tb_secure_sram_rekey;

    localparam int AW  = 4;
    localparam int DW  = 52;
    localparam int TAW = 64;
    localparam int TDW = 32;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           dcr;
    logic [TAW-1:0] trng_a_in;
    logic [TDW-1:0] trng_d_in;
    logic           req_valid;
    logic           req_ready;
    logic           req_we;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic           busy;
    logic [CW-1:0]  rekey_cnt;

    secure_sram_rekey #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRNG_A_WIDTH(TAW),
        .TRNG_D_WIDTH(TDW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .dcr(dcr),
        .trng_a_in(trng_a_in), .trng_d_in(trng_d_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .busy(busy), .rekey_cnt(rekey_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          vecs [10];
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;
    int            run = 0;
    int            maxrun = 0;
    int            lat;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] e);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        chk("req_ready_at_issue", 64'(req_ready), 64'd1);
        if (!we) exp_q.push_back(e);
        step();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            step();
            n++;
        end
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 50) begin
            if (busy !== 1'b1) begin
                chk("busy_while_unready", 64'(busy), 64'd1);
            end
            step();
            n++;
        end
    endtask

    // Response checker: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            run++;
            if (run > maxrun) maxrun = run;
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_rdata), 64'hx);
            end else begin
                chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_q.pop_front()));
            end
        end else begin
            run = 0;
        end
    end

    initial begin
        vecs[0] = '{1'b1, 4'd3,  52'h123456789ABCD, 52'h0};
        vecs[1] = '{1'b0, 4'd3,  52'h0, 52'h123456789ABCD};
        vecs[2] = '{1'b1, 4'd0,  52'hFFFFFFFFFFFFF, 52'h0};
        vecs[3] = '{1'b1, 4'd15, 52'h0000000000001, 52'h0};
        vecs[4] = '{1'b0, 4'd0,  52'h0, 52'hFFFFFFFFFFFFF};
        vecs[5] = '{1'b0, 4'd15, 52'h0, 52'h0000000000001};
        vecs[6] = '{1'b0, 4'd7,  52'h0, 52'h0};
        vecs[7] = '{1'b1, 4'd7,  52'hA5A5A5A5A5A5A, 52'h0};
        vecs[8] = '{1'b0, 4'd7,  52'h0, 52'hA5A5A5A5A5A5A};
        vecs[9] = '{1'b0, 4'd3,  52'h0, 52'h123456789ABCD};

        rst       = 1'b1;
        dcr       = 1'b0;
        trng_a_in = 64'h5;
        trng_d_in = 32'hA5A5A5A5;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        step();
        step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rekey_cnt", 64'(rekey_cnt), 64'd0);
        rst = 1'b0;
        wait_ready(lat);
        chk("reset_unavail_cycles", 64'(lat), 64'd17);
        chk("busy_when_ready", 64'(busy), 64'd0);
        trng_a_in = 64'h33;
        trng_d_in = 32'hDEADBEEF;

        // Back-to-back reads of the scrubbed array.
        maxrun = 0;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 4'(i), '0, '0);
        end
        idle();
        drain();
        chk("stream_run", 64'(maxrun), 64'd16);
        chk("rekey_cnt_after_por", 64'(rekey_cnt), 64'd0);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end
        idle();
        drain();
        chk("phys_mem6", 64'(dut.mem_q[6]),
            64'(52'h123456789ABCD ^ 52'h5A5A5A5A5A5A5));

        // Read accepted in the dcr cycle must return old data.
        trng_a_in = 64'hF;
        trng_d_in = 32'h0;
        dcr = 1'b1;
        issue(1'b0, 4'd3, '0, 52'h123456789ABCD);
        dcr = 1'b0;
        idle();
        wait_ready(lat);
        chk("dcr_unavail_cycles", 64'(lat), 64'd17);
        chk("rekey_cnt_1", 64'(rekey_cnt), 64'd1);
        issue(1'b0, 4'd3, '0, '0);
        issue(1'b1, 4'd3, 52'h0FEDCBA987654, '0);
        issue(1'b0, 4'd3, '0, 52'h0FEDCBA987654);
        idle();
        drain();
        chk("phys_mem12_zero_key", 64'(dut.mem_q[12]), 64'h0FEDCBA987654);

        // dcr five cycles into scrub restarts the sequence.
        trng_a_in = 64'hA;
        trng_d_in = 32'h12345678;
        dcr = 1'b1;
        step();
        dcr = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("busy_mid_scrub", 64'(busy), 64'd1);
        dcr = 1'b1;
        step();
        dcr = 1'b0;
        wait_ready(lat);
        chk("restart_unavail_cycles", 64'(lat), 64'd17);
        chk("rekey_cnt_3", 64'(rekey_cnt), 64'd3);
        issue(1'b0, 4'd3, '0, '0);
        issue(1'b0, 4'd9, '0, '0);
        issue(1'b1, 4'd9, 52'h00000BEEF0001, '0);
        issue(1'b0, 4'd9, '0, 52'h00000BEEF0001);
        idle();
        drain();

        for (int i = 0; i < 260; i++) begin
            dcr = 1'b1;
            step();
            dcr = 1'b0;
            step();
            if (i == 250) chk("rekey_cnt_254", 64'(rekey_cnt), 64'd254);
        end
        chk("rekey_cnt_sat", 64'(rekey_cnt), 64'd255);
        dcr = 1'b1;
        step();
        dcr = 1'b0;
        wait_ready(lat);
        chk("sat_unavail_cycles", 64'(lat), 64'd17);
        chk("rekey_cnt_sat_hold", 64'(rekey_cnt), 64'd255);
        issue(1'b0, 4'd0, '0, '0);
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/secure_sram_rekey.md
# secure_sram_rekey

Parametrised successor of the secure SRAM top. It adds an on-chip key register pair and a crypto-erase scrub engine, so a data corruption request (dcr) re-keys the memory and zeroises every physical word. Host access uses a valid/ready request channel and a fixed-latency response channel. It sits between the host memory port and the TRNG and owns its own storage array.

## Interface
- ADDR_WIDTH, 4: logical and physical address width. Depth is fixed at 2**ADDR_WIDTH.
- DATA_WIDTH, 52: word width.
- TRNG_A_WIDTH, 64: address-key input width. Must be >= ADDR_WIDTH.
- TRNG_D_WIDTH, 32: data-key input width.
- CNT_WIDTH, 8: width of rekey_cnt.

One clock; reset is asynchronous and active-high.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- dcr  in  1  data corruption request; sampled each cycle.
- trng_a_in  in  TRNG_A_WIDTH  address-key source, captured in LOAD.
- trng_d_in  in  TRNG_D_WIDTH  data-key source, captured in LOAD.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  logical address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  one-cycle read-data strobe.
- rsp_rdata  out  DATA_WIDTH  demapped read data; holds its value between strobes.
- busy  out  1  equals !req_ready.
- rekey_cnt  out  CNT_WIDTH  count of dcr-initiated rekeys; saturating.

## Operation
- **Keys:** key_a is TRNG_A_WIDTH bits and key_d is TRNG_D_WIDTH bits. Both are written only in the LOAD state.
- **Address map:** phys = addr XOR key_a[ADDR_WIDTH-1:0]. This is a bijection.
- **Data map:** kd = key_d replicated and truncated to DATA_WIDTH, with the LSB aligned. Stored word = data XOR kd. Demap uses the same XOR.
- **States:**
  - **LOAD:** 1 cycle.
    - key_a <= trng_a_in, key_d <= trng_d_in, scrub_ptr <= 0.
    - Next state is SCRUB.
  - **SCRUB:** 2**ADDR_WIDTH cycles.
    - Each cycle writes mem[scrub_ptr] <= kd, so a logical read returns 0, and increments scrub_ptr.
    - At scrub_ptr = all-ones, next state is ACTIVE. The pointer wraps to 0.
  - **ACTIVE:**
    - req_ready = 1.
    - A request is accepted when req_valid && req_ready.
    - Write: mem[phys] <= req_wdata XOR kd on the accept edge.
    - Read: mem[phys] is registered on the accept edge together with the current kd.
- **Transitions:**
  - Reset release -> LOAD. The power-on rekey does not count toward rekey_cnt.
  - dcr=1 in any state -> LOAD on the next edge. rekey_cnt increments and saturates at all-ones.
  - dcr in LOAD or SCRUB restarts the sequence from LOAD with fresh keys; scrub_ptr restarts at 0.
- **dcr and an accepted request in the same ACTIVE cycle:** the request completes, because req_ready was already high.
- **In-flight reads:** a read accepted before a rekey still returns its data, demapped with the kd captured at acceptance. Its response is not suppressed.
- **Requests outside ACTIVE:** req_valid outside ACTIVE is ignored; req_ready = 0.
- **Memory on reset:** contents are not reset. They are cleared by the post-reset scrub.

## Timing
- **Reset values:** req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rekey_cnt=0, state=LOAD, keys=0, scrub_ptr=0.
- **Unavailable window:** after reset release or a dcr, req_ready stays low for 1 + 2**ADDR_WIDTH cycles. That is 17 cycles at ADDR_WIDTH=4.
- **Read latency:** for a read accepted at edge N, rsp_valid is high for the cycle following edge N+1, and rsp_rdata is valid there. Latency is 2 edges: one array register, one demap/output register.
- **Throughput:** back-to-back reads sustain 1 response per cycle.
- **Read after write:**
  - Write accepted at edge N, read of the same address accepted at edge N+1: the read returns the new data.
  - Read and write to the same address cannot occur in the same cycle, since there is one request port.
- **Scrub writes:** they do not disturb a read already registered before LOAD.

## Test plan
- **Reset and scrub:** assert rst, release it with trng_a_in=0x5, trng_d_in=0xA5A5A5A5 -> req_ready rises exactly 17 cycles later. Every logical read returns 0, and rekey_cnt=0.
- **Write then read:** write addr 3 with 0x123456789ABCD, then read addr 3 the next cycle -> rsp_rdata=0x123456789ABCD two edges after the read accept. Physical mem[6] = 0x123456789ABCD ^ 0x5A5A5A5A5A5A5-pattern kd.
- **dcr re-key:** pulse dcr with new keys trng_a_in=0xF, trng_d_in=0x0 -> busy for 17 cycles and rekey_cnt=1. A read of addr 3 then returns 0.
- **dcr restart:** pulse dcr 5 cycles into SCRUB -> scrub restarts at 0, and req_ready returns 17 cycles after the second dcr edge.
- **In-flight read:** accept a read of addr 3 in the same cycle as dcr -> rsp_valid fires 2 edges later carrying the old data 0x123456789ABCD.
- **Streaming reads and saturation:** issue 16 consecutive reads -> 16 consecutive rsp_valid cycles. Then issue 260 dcr pulses -> rekey_cnt=255.
